// File: rtl/fetch_unit.sv
// Instruction fetch sequencer between the program counter and the decoder.
// Each instruction is read as two bytes, PC first and then PC+1, using a
// ready handshake. The bytes are joined into a 16-bit instruction register,
// and the register is offered to the decoder with a valid/ack handshake.
module fetch_unit #(
    parameter bit          LITTLE_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT       = 15,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        flush,
    output logic        pc_read,
    output logic        pc_readplusone,
    output logic        pc_inc,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_din,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic        bus_err
);

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_LO    = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_VALID = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_lo_byte;
    logic [15:0]      r_ir;
    logic             r_ir_valid;
    logic             r_bus_err;
    logic             w_timeout_hit;
    logic             w_capture_lo;
    logic             w_capture_hi;

    // A wait state times out once the counter has reached TIMEOUT and memory is still not ready.
    always_comb begin
        w_timeout_hit = (TIMEOUT != 0) && (r_count == C_TIMEOUT) && !mem_ready;
        w_capture_lo  = !flush && (r_state == S_LO) && run && mem_ready;
        w_capture_hi  = !flush && (r_state == S_HI) && mem_ready;
    end

    // Next state. Flush overrides every state, and run=0 during a flush parks the fetcher in START.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = run ? S_LO : S_START;
        end else begin
            case (r_state)
                S_START: if (run) w_next_state = S_LO;
                S_LO: begin
                    if (!run)               w_next_state = S_START;
                    else if (mem_ready)     w_next_state = S_HI;
                    else if (w_timeout_hit) w_next_state = S_ERR;
                end
                S_HI: begin
                    if (mem_ready)          w_next_state = S_VALID;
                    else if (w_timeout_hit) w_next_state = S_ERR;
                end
                S_VALID: if (ir_ack) w_next_state = S_LO;
                S_ERR:   w_next_state = S_ERR;
                default: w_next_state = S_START;
            endcase
        end
    end

    // State, wait counter, byte capture and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_START;
            r_count    <= '0;
            r_lo_byte  <= 8'h00;
            r_ir       <= 16'h0000;
            r_ir_valid <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ir_valid <= (w_next_state == S_VALID);
            if (flush || (w_next_state != r_state)) begin
                r_count <= '0;
            end else if (((r_state == S_LO) || (r_state == S_HI)) && (r_count != C_TIMEOUT)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_capture_lo) begin
                r_lo_byte <= mem_din;
            end
            if (w_capture_hi) begin
                r_ir <= LITTLE_ENDIAN ? {mem_din, r_lo_byte} : {r_lo_byte, mem_din};
            end
            if (w_next_state == S_ERR) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // The strobes depend only on the state. pc_inc also needs ready in HI and no flush.
    always_comb begin
        pc_read        = (r_state == S_LO);
        pc_readplusone = (r_state == S_HI);
        mem_rd         = (r_state == S_LO) || (r_state == S_HI);
        pc_inc         = (r_state == S_HI) && mem_ready && !flush;
        ir_out         = r_ir;
        ir_valid       = r_ir_valid;
        bus_err        = r_bus_err;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer that sits directly downstream of the program counter and upstream of the instruction decoder.
- Instructions are 16-bit and memory is byte-wide. The block drives the PC read strobes, fetches the low byte at PC and the high byte at PC+1 over a ready handshake, then pulses the PC increment (+2).
- It holds the assembled instruction in an instruction register and offers it to the decoder with a valid/ack handshake.
- It supports flush on branch and a bus-timeout error.

Parameters:
- LITTLE_ENDIAN, 1, 1: byte at PC is ir[7:0]; 0: byte at PC is ir[15:8].
- TIMEOUT, 15, max cycles to wait for mem_ready in a fetch state before error; 0 disables timeout.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  fetch enable; sampled in START and LO only.
- flush  input  1  discard any fetch or held instruction and restart at the current PC; asserted by branch logic in the same cycle it writes the PC.
- pc_read  output  1  to PC read: address bus = PC.
- pc_readplusone  output  1  to PC readplusone: address bus = PC+1.
- pc_inc  output  1  to PC inc: PC += 2 at the next edge.
- mem_rd  output  1  memory read request, valid while the address strobe is high.
- mem_ready  input  1  memory has mem_din valid this cycle.
- mem_din  input  8  memory read data.
- ir_out  output  16  instruction register.
- ir_valid  output  1  ir_out holds an unconsumed instruction.
- ir_ack  input  1  decoder consumes ir_out this cycle.
- bus_err  output  1  sticky timeout flag.

Behaviour:
- **States:** START, LO, HI, VALID, ERR. Registered: state, lo_byte[7:0], ir_out, ir_valid, bus_err, timeout counter.
- **Reset (reset=0, async):**
  - state=START, ir_out=16'h0000, ir_valid=0, bus_err=0, counter=0, lo_byte=0.
  - All strobes (pc_read, pc_readplusone, pc_inc, mem_rd) are 0 in START.
- **Strobes:** combinational from state only, plus mem_ready for pc_inc.
  - LO: pc_read=1, mem_rd=1.
  - HI: pc_readplusone=1, mem_rd=1.
  - pc_inc=1 only in the HI cycle where mem_ready=1 and flush=0.
  - pc_read and pc_readplusone are never high together (single-driver address bus).
- **START:** run=1 -> LO, else stay.
- **LO:** run=0 and flush=0 -> START; no byte is captured.
  - Otherwise, mem_ready=1 -> latch lo_byte=mem_din, counter=0, go to HI.
  - Otherwise counter increments.
- **HI:** mem_ready=1 -> ir_out assembled per LITTLE_ENDIAN from {mem_din, lo_byte}, ir_valid=1, counter=0, go to VALID.
  - PC has incremented at the same edge via pc_inc.
  - Otherwise counter increments. run is ignored in HI.
- **VALID:** ir_valid=1, ir_out held stable.
  - ir_ack=1 -> ir_valid=0, go to LO (next fetch starts the following cycle).
  - Fetch latency from ack: 2 cycles minimum (LO, HI each 1 cycle with zero-wait memory); a new ir_valid appears on the 3rd edge after ack.
- **Timeout:** in LO or HI, when counter==TIMEOUT and mem_ready=0 (and TIMEOUT!=0):
  - go to ERR, bus_err=1, strobes 0.
  - ERR holds until flush; bus_err stays set until reset.
- **Flush (highest priority after reset):** in any state, flush=1 -> next state LO (START if run=0).
  - ir_valid=0, counter=0, no capture.
  - pc_inc forced 0 even if mem_ready=1 in HI.
  - flush together with ir_ack in VALID: flush wins; the handshake is treated as completed.
- **Counter:** saturates at TIMEOUT; cleared on every state change.
- ir_out is not cleared on flush or ack, only on reset; consumers qualify with ir_valid.
- **Reset mid-fetch:** immediately returns to START with strobes low; any partial lo_byte is discarded.

Test Plan:
- **Basic fetch:** reset low 2 cycles, release; run=1, mem_ready=1 always, mem_din=8'h34 in LO, 8'h12 in HI.
  - Required: LO pc_read=1, HI pc_readplusone=1 and pc_inc=1, then ir_out=16'h1234, ir_valid=1 (LITTLE_ENDIAN=1).
- **Wait states:** mem_ready low 3 cycles in LO and 2 in HI.
  - Required: strobes held steady, no pc_inc until the HI ready cycle, ir_out correct, exactly one pc_inc.
- **Decoder backpressure:** ir_ack=0 for 5 cycles in VALID.
  - Required: ir_valid and ir_out stable, no strobes.
  - Then ack=1 -> LO next cycle; with zero-wait memory the next ir_valid appears 3 edges later.
- **Flush in HI with mem_ready=1:**
  - Required: pc_inc=0, no ir_valid, next state LO with pc_read=1.
  - Also: flush+ack in VALID -> ir_valid=0, fetch restarts.
- **Timeout:** TIMEOUT=15, mem_ready held 0 in LO.
  - Required: after 16 cycles in LO, bus_err=1, all strobes 0, ERR held.
  - flush -> LO, bus_err remains 1; reset clears it.
- **Reset mid-operation and run:** assert reset in HI -> strobes 0 asynchronously, ir_valid=0.
  - run=0 after release -> stays in START with no strobes.
